img_mem_ctrl: RTL and testbench
===============================

# img_mem_ctrl

Sequencing and arbitration controller for the single-port image memory in the NN datapath. Fills the memory with one image from a valid/ready pixel stream at sequential addresses 0..DEPTH-1, then serves random-access reads from the NN core until the core releases the image. Owns the memory's we/en/addr/din pins exclusively; no other block drives them.

## Interface
- DEPTH, default WIDTH (nn_param_pkg): image words stored.
- ADDR_W, default ADDR_OUT (nn_param_pkg): memory address width.
- DATA_W, default INT_BITS + FRC_BITS (nn_param_pkg): pixel word width.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  loader pixel valid.
- s_ready  out  1  loader pixel accepted this cycle when high with s_valid.
- s_data  in  DATA_W  loader pixel.
- rd_req  in  1  NN read request, single-cycle per request.
- rd_addr  in  ADDR_W  NN read address.
- rd_valid  out  1  registered read data valid.
- rd_data  out  DATA_W  registered read data.
- rd_err  out  1  registered: request refused or address >= DEPTH.
- img_ready  out  1  image fully loaded (state FULL).
- img_done  in  1  NN releases image; pulse.
- load_abort  in  1  synchronous discard of partial/full image.
- mem_we, mem_en  out  1 each  memory write enable / enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data, combinational from mem_addr when en & !we.

## Operation
- States: LOAD, FULL. Reset state LOAD, wr_ptr = 0.
- LOAD: s_ready = 1 unless a read is granted (see Configuration). Handshake (s_valid & s_ready) -> mem_en=1, mem_we=1, mem_addr=wr_ptr, mem_din=s_data; wr_ptr++. Handshake at wr_ptr == DEPTH-1 -> wr_ptr=0, state FULL.
- FULL: s_ready = 0, img_ready = 1. rd_req with rd_addr < DEPTH -> mem_en=1, mem_we=0, mem_addr=rd_addr; mem_dout captured into rd_data. rd_addr >= DEPTH -> no memory access, rd_err=1, rd_data=0.
- img_done in FULL -> LOAD next cycle, wr_ptr=0. img_done in LOAD ignored.
- rd_req in LOAD (macro off) -> refused: rd_valid=1, rd_err=1, rd_data=0. Every rd_req gets exactly one response.
- Same-cycle rd_req and img_done in FULL: read served, then transition.
- load_abort: highest priority; next cycle state LOAD, wr_ptr=0; a same-cycle loader handshake is not taken (s_ready forced 0); a same-cycle rd_req is refused with rd_err.
- Idle cycles: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- Memory contents are never cleared; a new image overwrites.

## Timing
- Reset values: s_ready=1 after reset release (LOAD), rd_valid=0, rd_data=0, rd_err=0, img_ready=0, all mem_* = 0.
- Memory pins and s_ready are combinational from state, wr_ptr, rd_req, rd_addr, load_abort.
- Read latency 1: rd_req in cycle N -> rd_valid/rd_data/rd_err in N+1 for one cycle. Back-to-back reads: one per cycle.
- Load throughput 1 word/cycle; DEPTH handshakes -> img_ready high the cycle after the last handshake.
- img_done in N -> img_ready low and s_ready high in N+1.

## Configuration
- IMG_MEM_CTRL_OVERLAP_EN defined: in LOAD, rd_req with rd_addr < wr_ptr is served (read priority: s_ready=0 that cycle, loader stalls); rd_addr >= wr_ptr refused with rd_err. Lets the NN start on leading pixels.
- Undefined: all reads in LOAD refused with rd_err; s_ready independent of rd_req.

## Test plan
- DEPTH=8: stream 8 pixels 0x10..0x17 with continuous s_valid -> mem writes at addr 0..7, img_ready high 1 cycle after 8th handshake, s_ready low in FULL.
- FULL: rd_req addr 3, then addr 7 back-to-back -> rd_data 0x13 then 0x17 in consecutive cycles, rd_err=0.
- FULL: rd_req addr 8 (>= DEPTH) -> rd_valid=1, rd_err=1, rd_data=0, mem_en=0.
- After 5 pixels, load_abort -> wr_ptr=0, next 8 pixels 0x20..0x27 land at addr 0..7; img_done with rd_req addr 0 same cycle -> rd_data 0x20, then LOAD.
- Macro on: after 4 pixels, rd_req addr 2 with s_valid=1 -> s_ready=0 that cycle, rd_data=0x12; rd_req addr 5 -> rd_err=1. Macro off: same reads both rd_err=1, loader not stalled.
- Assert rst_n low mid-load and mid-read -> all outputs at reset values immediately; resume load from addr 0.

Source files
------------

// File: rtl/img_mem_ctrl.sv
// img_mem_ctrl: sole owner of the single-port image memory pins.
// Streams one image in at addresses 0..DEPTH-1 (LOAD), then serves
// single-cycle-latency random reads from the NN core (FULL) until the
// core releases the image with img_done.
// Optional feature macro: IMG_MEM_CTRL_OVERLAP_EN -- when defined, reads
// of already-written words are served during LOAD (read wins, loader stalls).
module img_mem_ctrl #(
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              img_ready,
  input  logic              img_done,
  input  logic              load_abort,
  output logic              mem_we,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic              in_range, rd_grant, wr_hs;
  rsp_t              rsp_q, rsp_d;

  assign in_range = ({1'b0, rd_addr} < DEPTH_X);

  // State and write pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      wr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
    end
  end

  // Next state: abort dominates, last handshake fills, img_done releases
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    if (load_abort) begin
      state_nxt  = LOAD;
      wr_ptr_nxt = '0;
    end else if (state == LOAD) begin
      if (wr_hs) begin
        if (wr_ptr == LAST) begin
          state_nxt  = FULL;
          wr_ptr_nxt = '0;
        end else begin
          wr_ptr_nxt = wr_ptr + 1'b1;
        end
      end
    end else if (img_done) begin
      state_nxt  = LOAD;
      wr_ptr_nxt = '0;
    end
  end

  // Outputs: read grant, loader handshake and memory pins (all combinational).
  // rst_n gates the handshake so nothing is written while reset is held.
  always_comb begin
    rd_grant = 1'b0;
    if (rst_n && !load_abort && rd_req) begin
      if (state == FULL) rd_grant = in_range;
`ifdef IMG_MEM_CTRL_OVERLAP_EN
      else               rd_grant = (rd_addr < wr_ptr);
`endif
    end
    s_ready   = rst_n && !load_abort && (state == LOAD) && !rd_grant;
    wr_hs     = s_valid && s_ready;
    img_ready = (state == FULL);
    mem_en    = wr_hs || rd_grant;
    mem_we    = wr_hs;
    mem_addr  = '0;
    mem_din   = '0;
    if (wr_hs) begin
      mem_addr = wr_ptr;
      mem_din  = s_data;
    end else if (rd_grant) begin
      mem_addr = rd_addr;
    end
  end

  // Every request gets one response next cycle; refused ones return err, data 0
  always_comb begin
    rsp_d.vld  = rd_req;
    rsp_d.err  = rd_req && !rd_grant;
    rsp_d.data = rd_grant ? mem_dout : '0;
  end

  // Registered read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_q <= '0;
    else        rsp_q <= rsp_d;
  end

  assign rd_valid = rsp_q.vld;
  assign rd_err   = rsp_q.err;
  assign rd_data  = rsp_q.data;

endmodule

// File: tb/tb_img_mem_ctrl.sv
// Scoreboard bench for img_mem_ctrl (DEPTH=8). Read responses are queued
// when a request is issued and popped by an independent monitor.
module tb_img_mem_ctrl;
  localparam int DEPTH = 8, ADDR_W = 4, DATA_W = 8;

  logic clk = 1'b0, rst_n;
  logic s_valid, s_ready, rd_req, rd_valid, rd_err, img_ready, img_done, load_abort;
  logic mem_we, mem_en;
  logic [DATA_W-1:0] s_data, rd_data, mem_din, mem_dout;
  logic [ADDR_W-1:0] rd_addr, mem_addr;

  logic [DATA_W-1:0] mem [0:15];
  logic [8:0] q [$];
  int n_chk = 0, n_fail = 0;

  img_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err), .img_ready(img_ready), .img_done(img_done), .load_abort(load_abort),
    .mem_we(mem_we), .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = (mem_en && !mem_we) ? mem[mem_addr] : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid must match the oldest expected response
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (q.size() == 0) chk("sb_unexpected_rsp", 1, 0);
      else begin
        logic [8:0] e;
        e = q.pop_front();
        chk("sb_rd_err", rd_err, e[8]);
        chk("sb_rd_data", rd_data, e[7:0]);
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    s_valid = 0; rd_req = 0; img_done = 0; load_abort = 0;
  endtask

  task automatic px(input logic [7:0] d, input logic [3:0] a);
    s_valid = 1; s_data = d;
    @(negedge clk);
    chk("ld_s_ready", s_ready, 1);
    chk("ld_mem_en", mem_en, 1);
    chk("ld_mem_we", mem_we, 1);
    chk("ld_mem_addr", mem_addr, a);
    chk("ld_mem_din", mem_din, d);
    chk("ld_img_ready", img_ready, 0);
    tick();
  endtask

  task automatic rd(input logic [3:0] a, input logic err, input logic [7:0] d, input logic en);
    rd_req = 1; rd_addr = a;
    q.push_back({err, d});
    @(negedge clk);
    chk("rd_mem_en", mem_en, en);
    if (en) begin
      chk("rd_mem_we", mem_we, 0);
      chk("rd_mem_addr", mem_addr, a);
    end
    tick();
    rd_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ptr;
    idle(); s_data = 0; rd_addr = 0; rst_n = 0;
    // Reset state
    #12;
    chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_err", rd_err, 0); chk("rst_img_ready", img_ready, 0);
    chk("rst_mem_en", mem_en, 0); chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_din", mem_din, 0);
    tick(); rst_n = 1;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);
    tick();

    // Image 1: 0x10..0x17, continuous s_valid
    for (int i = 0; i < 8; i++) px(8'h10 + 8'(i), 4'(i));
    s_data = 8'h99;  // s_valid still high: must be refused in FULL
    @(negedge clk);
    chk("full_img_ready", img_ready, 1);
    chk("full_s_ready", s_ready, 0);
    chk("full_mem_en", mem_en, 0);
    for (int i = 0; i < 8; i++) chk("mem_content", mem[i], 8'h10 + 8'(i));
    tick(); s_valid = 0;

    // Back-to-back reads, then out-of-range read
    rd(4'd3, 0, 8'h13, 1);
    rd(4'd7, 0, 8'h17, 1);
    rd(4'd8, 1, 8'h00, 0);
    // img_done with same-cycle read: read served, then LOAD
    img_done = 1;
    rd(4'd0, 0, 8'h10, 1);
    img_done = 0;
    @(negedge clk);
    chk("done_img_ready", img_ready, 0);
    chk("done_s_ready", s_ready, 1);
    tick();

    // Partial load then abort with pending pixel and read
    for (int i = 0; i < 5; i++) px(8'h30 + 8'(i), 4'(i));
    s_data = 8'h35; load_abort = 1; rd_req = 1; rd_addr = 0;
    q.push_back({1'b1, 8'h00});
    @(negedge clk);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_mem_en", mem_en, 0);
    tick(); load_abort = 0; rd_req = 0;
    for (int i = 0; i < 8; i++) px(8'h20 + 8'(i), 4'(i));
    s_valid = 0;
    @(negedge clk);
    chk("img2_ready", img_ready, 1);
    tick();
    img_done = 1;
    rd(4'd0, 0, 8'h20, 1);
    img_done = 0;
    @(negedge clk);
    chk("img2_done_ready", img_ready, 0);
    tick();

    // Reads during LOAD after 4 pixels
    for (int i = 0; i < 4; i++) px(8'h10 + 8'(i), 4'(i));
    ptr = 4;
    s_valid = 1; s_data = 8'h10 + 8'(ptr); rd_req = 1; rd_addr = 2;
`ifdef IMG_MEM_CTRL_OVERLAP_EN
    q.push_back({1'b0, 8'h12});
    @(negedge clk);
    chk("ovl_s_ready_stall", s_ready, 0);
    chk("ovl_mem_en", mem_en, 1);
    chk("ovl_mem_we", mem_we, 0);
    chk("ovl_mem_addr", mem_addr, 2);
`else
    q.push_back({1'b1, 8'h00});
    @(negedge clk);
    chk("ovl_s_ready", s_ready, 1);
    chk("ovl_mem_we", mem_we, 1);
    chk("ovl_mem_addr", mem_addr, 4'(ptr));
    ptr++;
`endif
    tick();
    s_data = 8'h10 + 8'(ptr); rd_addr = 5;
    q.push_back({1'b1, 8'h00});
    @(negedge clk);
    chk("ovl2_s_ready", s_ready, 1);
    chk("ovl2_mem_we", mem_we, 1);
    chk("ovl2_mem_addr", mem_addr, 4'(ptr));
    chk("ovl2_mem_din", mem_din, 8'h10 + 8'(ptr));
    tick(); rd_req = 0;

    // Reset mid-load (s_valid held high)
    s_data = 8'h77;
    rst_n = 0; q.delete();
    #1;
    chk("mrst_img_ready", img_ready, 0); chk("mrst_rd_valid", rd_valid, 0);
    chk("mrst_rd_err", rd_err, 0); chk("mrst_rd_data", rd_data, 0);
    chk("mrst_mem_we", mem_we, 0); chk("mrst_mem_en", mem_en, 0);
    tick(); rst_n = 1;
    for (int i = 0; i < 8; i++) px(8'h40 + 8'(i), 4'(i));
    s_valid = 0;
    @(negedge clk);
    chk("img3_ready", img_ready, 1);
    tick();

    // Reset while a read response is being presented
    rd_req = 1; rd_addr = 1;
    tick(); rd_req = 0;
    chk("rsp_before_rst", rd_data, 8'h41);
    rst_n = 0; q.delete();
    #1;
    chk("rrst_rd_valid", rd_valid, 0); chk("rrst_rd_data", rd_data, 0);
    chk("rrst_rd_err", rd_err, 0); chk("rrst_img_ready", img_ready, 0);
    tick(); rst_n = 1;
    px(8'h50, 4'd0);
    s_valid = 0;

    repeat (3) tick();
    chk("sb_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
